// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// WIDTH+1 steps per operation, signed or unsigned operands selected per request.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_is_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH+1:0]   r_a;
    logic [WIDTH+1:0]   r_m;
    logic [WIDTH:0]     r_q;
    logic               r_q1;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH+1:0]   w_ext_m;
    logic [WIDTH:0]     w_ext_q;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH+1:0]   w_a_nxt;
    logic [WIDTH:0]     w_q_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic               w_load;

    // Unsigned operands get a zero top bit, so the same signed Booth datapath
    // handles both modes; the second guard bit on M keeps A +/- M from wrapping.
    assign w_ext_m = {{2{i_is_signed & i_multiplicand[WIDTH-1]}}, i_multiplicand};
    assign w_ext_q = {i_is_signed & i_multiplier[WIDTH-1], i_multiplier};

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_nxt    = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign w_q_nxt    = {w_sum[0], r_q[WIDTH:1]};
    assign w_prod_nxt = {w_a_nxt[WIDTH-2:0], w_q_nxt};

    assign w_load = i_start && (r_state != S_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_product <= '0;
        end else if (w_load) begin
            r_state <= S_RUN;
            r_cnt   <= CW'(WIDTH + 1);
            r_a     <= '0;
            r_m     <= w_ext_m;
            r_q     <= w_ext_q;
            r_q1    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state   <= S_DONE;
                        r_product <= w_prod_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready   = (r_state != S_RUN);
    assign o_busy    = (r_state == S_RUN);
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_product;

endmodule
